// File: rtl/copy_sched.sv
`default_nettype none
// ============================================================================
//  Module   : copy_sched
//  Purpose  : COPY-stage scheduler. Round-robin arbitration between two
//             four-phase packet producers, then replays the granted packet
//             to the copy datapath once per requested copy (Send/Ack
//             four-phase), tagging each copy with an index and a last flag.
//             Bypass packets are emitted exactly once with feb raised.
//  Revision : 1.0 - initial release
// ============================================================================
module copy_sched #(
  parameter int DW = 32,
  parameter int CW = 3
) (
  input  logic          CLK,
  input  logic          MR_n,
  // producer channel 0
  input  logic          Send_in0,
  input  logic [DW-1:0] Data_in0,
  input  logic [CW-1:0] Cnt_in0,
  input  logic          exb_in0,
  output logic          Ack_out0,
  // producer channel 1
  input  logic          Send_in1,
  input  logic [DW-1:0] Data_in1,
  input  logic [CW-1:0] Cnt_in1,
  input  logic          exb_in1,
  output logic          Ack_out1,
  // copy datapath side
  output logic          Send_out,
  output logic [DW-1:0] Data_out,
  output logic [CW-1:0] Idx_out,
  output logic          Last_out,
  input  logic          Ack_in,
  // status
  output logic          feb,
  output logic          Busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMIT    = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

  localparam logic [CW:0] c_one = {{CW{1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_nxt;

  // Registered state. Data_out doubles as the latched packet: it is only
  // loaded on the grant edge, which is also the first Send_out rising edge.
  logic          r_ptr;
  logic          r_gnt;
  logic [CW:0]   r_k;
  logic [CW:0]   r_total;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_send;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_idx;
  logic          r_last;
  logic          r_feb;
  logic          r_busy;

  logic          w_ptr_nxt;
  logic          w_gnt_nxt;
  logic [CW:0]   w_k_nxt;
  logic [CW:0]   w_total_nxt;
  logic          w_ack0_nxt;
  logic          w_ack1_nxt;
  logic          w_send_nxt;
  logic [DW-1:0] w_data_nxt;
  logic [CW-1:0] w_idx_nxt;
  logic          w_last_nxt;
  logic          w_feb_nxt;
  logic          w_busy_nxt;

  // Arbitration and selected-channel view
  logic          w_elig0;
  logic          w_elig1;
  logic          w_any;
  logic          w_sel;
  logic [DW-1:0] w_sel_data;
  logic [CW-1:0] w_sel_cnt;
  logic          w_sel_exb;
  logic [CW:0]   w_k_inc;
  logic          w_is_last;

  // A channel whose acknowledge is still high has not finished its
  // four-phase return, so it cannot be granted again yet.
  assign w_elig0    = Send_in0 & ~r_ack0;
  assign w_elig1    = Send_in1 & ~r_ack1;
  assign w_any      = w_elig0 | w_elig1;
  assign w_sel      = (w_elig0 & w_elig1) ? r_ptr : w_elig1;
  assign w_sel_data = w_sel ? Data_in1 : Data_in0;
  assign w_sel_cnt  = w_sel ? Cnt_in1  : Cnt_in0;
  assign w_sel_exb  = w_sel ? exb_in1  : exb_in0;
  assign w_k_inc    = r_k + c_one;
  assign w_is_last  = (r_k == (r_total - c_one));

  // State register
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; a reset drops any packet in flight
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_k     <= '0;
      r_total <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_feb   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_k     <= w_k_nxt;
      r_total <= w_total_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_send  <= w_send_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_feb   <= w_feb_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_k_nxt     = r_k;
    w_total_nxt = r_total;
    w_ack0_nxt  = r_ack0;
    w_ack1_nxt  = r_ack1;
    w_send_nxt  = r_send;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_feb_nxt   = r_feb;

    // Producer release runs independently of the emission sequence.
    if (!Send_in0) w_ack0_nxt = 1'b0;
    if (!Send_in1) w_ack1_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_sel;
          w_data_nxt  = w_sel_data;
          w_k_nxt     = '0;
          w_total_nxt = w_sel_exb ? c_one : ({1'b0, w_sel_cnt} + c_one);
          w_idx_nxt   = '0;
          w_last_nxt  = w_sel_exb | (w_sel_cnt == '0);
          w_feb_nxt   = w_sel_exb;
          w_send_nxt  = 1'b1;
          if (w_sel) w_ack1_nxt = 1'b1;
          else       w_ack0_nxt = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end

      S_EMIT: begin
        if (Ack_in) begin
          w_send_nxt  = 1'b0;
          w_state_nxt = S_WAIT_LO;
        end
      end

      S_WAIT_LO: begin
        if (!Ack_in) begin
          if (w_is_last) begin
            w_last_nxt  = 1'b0;
            w_idx_nxt   = '0;
            w_feb_nxt   = 1'b0;
            w_ptr_nxt   = ~r_gnt;
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt     = w_k_inc;
            w_idx_nxt   = w_k_inc[CW-1:0];
            w_last_nxt  = (w_k_inc == (r_total - c_one));
            w_send_nxt  = 1'b1;
            w_state_nxt = S_EMIT;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign Ack_out0 = r_ack0;
  assign Ack_out1 = r_ack1;
  assign Send_out = r_send;
  assign Data_out = r_data;
  assign Idx_out  = r_idx;
  assign Last_out = r_last;
  assign feb      = r_feb;
  assign Busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_copy_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_copy_sched
//  Purpose  : Directed scoreboard bench for copy_sched. Expected copies are
//             queued when a producer packet is issued and compared as the
//             datapath side sees each Send_out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_copy_sched;

  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int LIM = 400;

  logic          CLK = 1'b0;
  logic          MR_n = 1'b0;
  logic          Send_in0 = 1'b0;
  logic [DW-1:0] Data_in0 = '0;
  logic [CW-1:0] Cnt_in0 = '0;
  logic          exb_in0 = 1'b0;
  logic          Ack_out0;
  logic          Send_in1 = 1'b0;
  logic [DW-1:0] Data_in1 = '0;
  logic [CW-1:0] Cnt_in1 = '0;
  logic          exb_in1 = 1'b0;
  logic          Ack_out1;
  logic          Send_out;
  logic [DW-1:0] Data_out;
  logic [CW-1:0] Idx_out;
  logic          Last_out;
  logic          Ack_in = 1'b0;
  logic          feb;
  logic          Busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] idx;
    logic          last;
    logic          fb;
  } exp_t;

  exp_t exp_q[$];

  copy_sched #(.DW(DW), .CW(CW)) dut (
    .CLK(CLK), .MR_n(MR_n),
    .Send_in0(Send_in0), .Data_in0(Data_in0), .Cnt_in0(Cnt_in0),
    .exb_in0(exb_in0), .Ack_out0(Ack_out0),
    .Send_in1(Send_in1), .Data_in1(Data_in1), .Cnt_in1(Cnt_in1),
    .exb_in1(exb_in1), .Ack_out1(Ack_out1),
    .Send_out(Send_out), .Data_out(Data_out), .Idx_out(Idx_out),
    .Last_out(Last_out), .Ack_in(Ack_in), .feb(feb), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the copies a packet should produce, in emission order.
  task automatic expect_pkt(input logic [DW-1:0] d, input logic [CW-1:0] cnt, input logic e);
    int total;
    exp_t x;
    total = e ? 1 : int'(cnt) + 1;
    for (int i = 0; i < total; i++) begin
      x.d    = d;
      x.idx  = CW'(i);
      x.last = (i == total - 1);
      x.fb   = e;
      exp_q.push_back(x);
    end
  endtask

  function automatic logic ack_of(input int ch);
    return (ch == 0) ? Ack_out0 : Ack_out1;
  endfunction

  // One four-phase producer transaction on channel ch.
  task automatic produce(input int ch, input logic [DW-1:0] d, input logic [CW-1:0] c, input logic e);
    int n;
    if (ch == 0) begin
      Data_in0 = d; Cnt_in0 = c; exb_in0 = e; Send_in0 = 1'b1;
    end else begin
      Data_in1 = d; Cnt_in1 = c; exb_in1 = e; Send_in1 = 1'b1;
    end
    n = 0;
    while (ack_of(ch) !== 1'b1 && n < LIM) begin @(negedge CLK); n++; end
    chk($sformatf("ack_hi_ch%0d", ch), 64'(ack_of(ch)), 64'd1);
    if (ch == 0) Send_in0 = 1'b0;
    else         Send_in1 = 1'b0;
    n = 0;
    while (ack_of(ch) !== 1'b0 && n < LIM) begin @(negedge CLK); n++; end
    chk($sformatf("ack_lo_ch%0d", ch), 64'(ack_of(ch)), 64'd0);
  endtask

  // Datapath-side consumer: accepts n copies, delaying each handshake
  // phase by dly cycles, and scores every copy against the queue.
  task automatic consume(input int n, input int dly);
    exp_t e;
    int   w;
    e.d = '0; e.idx = '0; e.last = 1'b0; e.fb = 1'b0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (Send_out !== 1'b1 && w < LIM) begin @(negedge CLK); w++; end
      chk("send_rise", 64'(Send_out), 64'd1);
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("data", 64'(Data_out), 64'(e.d));
      chk("idx",  64'(Idx_out),  64'(e.idx));
      chk("last", 64'(Last_out), 64'(e.last));
      chk("feb",  64'(feb),      64'(e.fb));
      chk("busy", 64'(Busy),     64'd1);
      for (int j = 0; j < dly; j++) begin
        @(negedge CLK);
        chk("hold_data", 64'(Data_out), 64'(e.d));
        chk("hold_idx",  64'(Idx_out),  64'(e.idx));
        chk("hold_send", 64'(Send_out), 64'd1);
      end
      Ack_in = 1'b1;
      w = 0;
      while (Send_out !== 1'b0 && w < LIM) begin @(negedge CLK); w++; end
      chk("send_fall", 64'(Send_out), 64'd0);
      for (int j = 0; j < dly; j++) begin
        @(negedge CLK);
        chk("no_rerise", 64'(Send_out), 64'd0);
        chk("hold_feb",  64'(feb),      64'(e.fb));
      end
      Ack_in = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag);
    repeat (3) @(negedge CLK);
    chk({tag, "_busy"}, 64'(Busy),     64'd0);
    chk({tag, "_send"}, 64'(Send_out), 64'd0);
    chk({tag, "_feb"},  64'(feb),      64'd0);
    chk({tag, "_last"}, 64'(Last_out), 64'd0);
    chk({tag, "_idx"},  64'(Idx_out),  64'd0);
    chk({tag, "_sb"},   64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_send", 64'(Send_out), 64'd0);
    chk("rst_ack0", 64'(Ack_out0), 64'd0);
    chk("rst_ack1", 64'(Ack_out1), 64'd0);
    chk("rst_data", 64'(Data_out), 64'd0);
    chk("rst_busy", 64'(Busy),     64'd0);
    chk("rst_feb",  64'(feb),      64'd0);
    MR_n = 1'b1;
    @(negedge CLK);

    // Simultaneous requests after reset: ch0 first, then strict alternation
    for (int i = 0; i < 3; i++) begin
      expect_pkt(32'h1000_0000 + 32'(i), 3'd2, 1'b0);
      expect_pkt(32'h2000_0000 + 32'(i), 3'd2, 1'b0);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) produce(0, 32'h1000_0000 + 32'(i), 3'd2, 1'b0);
      end
      begin
        for (int i = 0; i < 3; i++) produce(1, 32'h2000_0000 + 32'(i), 3'd2, 1'b0);
      end
      consume(18, 1);
    join
    chk_idle("arb_idle");

    // Single copy with acknowledge latency check
    chk("pre_ack0", 64'(Ack_out0), 64'd0);
    expect_pkt(32'hA5A5_A5A5, 3'd0, 1'b0);
    fork
      produce(0, 32'hA5A5_A5A5, 3'd0, 1'b0);
      begin
        @(negedge CLK);
        chk("ack0_latency", 64'(Ack_out0), 64'd1);
        chk("send_latency", 64'(Send_out), 64'd1);
      end
      consume(1, 0);
    join
    chk_idle("single_idle");

    // Multi copy on ch1
    expect_pkt(32'h3C3C_C3C3, 3'd3, 1'b0);
    fork
      produce(1, 32'h3C3C_C3C3, 3'd3, 1'b0);
      consume(4, 0);
    join
    chk_idle("multi_idle");

    // Bypass: Cnt ignored, exactly one emission flagged on feb
    expect_pkt(32'h5A5A_0000, 3'd5, 1'b1);
    fork
      produce(0, 32'h5A5A_0000, 3'd5, 1'b1);
      consume(1, 2);
    join
    chk_idle("bypass_idle");

    // Slow consumer, maximum copy count
    expect_pkt(32'h7777_0001, 3'd7, 1'b0);
    fork
      produce(1, 32'h7777_0001, 3'd7, 1'b0);
      consume(8, 7);
    join
    chk_idle("slow_idle");

    // Asynchronous reset in the middle of a packet
    Data_in0 = 32'hDEAD_BEEF; Cnt_in0 = 3'd3; exb_in0 = 1'b0; Send_in0 = 1'b1;
    w = 0;
    while (Send_out !== 1'b1 && w < LIM) begin @(negedge CLK); w++; end
    chk("mid_send", 64'(Send_out), 64'd1);
    #2 MR_n = 1'b0;
    #1;
    chk("arst_send", 64'(Send_out), 64'd0);
    chk("arst_ack0", 64'(Ack_out0), 64'd0);
    chk("arst_data", 64'(Data_out), 64'd0);
    chk("arst_busy", 64'(Busy),     64'd0);
    chk("arst_idx",  64'(Idx_out),  64'd0);
    chk("arst_last", 64'(Last_out), 64'd0);
    Send_in0 = 1'b0;
    @(negedge CLK);
    MR_n = 1'b1;
    @(negedge CLK);

    // Post-reset packet starts at copy index 0
    expect_pkt(32'hB0B0_0001, 3'd1, 1'b0);
    fork
      produce(0, 32'hB0B0_0001, 3'd1, 1'b0);
      consume(2, 0);
    join
    chk_idle("post_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
